// File: rtl/stream_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module  : stream_capture_buffer
// Brief   : Captures triggered multi-channel records into a FIFO and streams
//           them out one channel word per beat.
// Rev     : 1.0  initial release
// ============================================================================
module stream_capture_buffer #(
  parameter int DSIZE         = 32,
  parameter int CHANNELS      = 4,
  parameter int DEPTH         = 16,
  parameter int TRIGGER_TOTAL = 1000
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                trig_mode,
  input  logic                      trigger,
  input  logic [CHANNELS*DSIZE-1:0] data,
  output logic [DSIZE-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [31:0]               count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW = CHANNELS * DSIZE;

  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);
  localparam logic [31:0]   TOTAL    = 32'(TRIGGER_TOTAL);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;

  logic [1:0]    state_q,    state_d;
  logic          trig_q,     trig_d;
  logic [AW:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW:0]   rd_ptr_q,   rd_ptr_d;
  logic [31:0]   count_q,    count_d;
  logic          overflow_q, overflow_d;
  logic          valid_q,    valid_d;
  logic [CW-1:0] idx_q,      idx_d;
  logic [RW-1:0] rec_q,      rec_d;

  logic [RW-1:0] mem_q [DEPTH];

  logic          w_mode_hit;
  logic          w_event;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_beat;
  logic          w_last_beat;
  logic          w_pop;
  logic [RW-1:0] w_head;
  logic [DSIZE-1:0] w_words [CHANNELS];

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign w_fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_head       = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    w_mode_hit = 1'b0;
    case (trig_mode)
      MODE_RISE: w_mode_hit =  trigger & ~trig_q;
      MODE_FALL: w_mode_hit = ~trigger &  trig_q;
      MODE_BOTH: w_mode_hit =  trigger ^  trig_q;
      default:   w_mode_hit = 1'b1;
    endcase
  end

  assign w_event = enable & w_mode_hit & (state_q == ST_CAPTURE);
  // Fullness is judged before any same-cycle pop, so a full FIFO drops the event.
  assign w_push  = w_event & ~w_fifo_full;

  assign w_beat      = valid_q & out_ready;
  assign w_last_beat = w_beat & (idx_q == LAST_IDX);
  assign w_pop       = ~w_fifo_empty & (~valid_q | w_last_beat);

  always_comb begin
    trig_d     = trigger;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      count_d  = count_q + 32'd1;
    end
    if (w_event && w_fifo_full) begin
      overflow_d = 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Serializer: a new record may load on the same edge the previous last beat leaves.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    if (w_pop) begin
      rec_d   = w_head;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (w_last_beat) begin
      valid_d = 1'b0;
    end else if (w_beat) begin
      idx_d = idx_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (count_d == TOTAL) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_fifo_empty && !valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      rec_q      <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign w_words[gi] = rec_q[gi*DSIZE +: DSIZE];
  end

  assign out_data  = w_words[idx_q];
  assign out_valid = valid_q;
  assign out_last  = valid_q & (idx_q == LAST_IDX);
  assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule
`default_nettype wire
